// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// enables and selects, and runs the memory req/ack handshake with a timeout.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        Clk,
  input  logic        Resetin,
  input  logic [31:0] Instr,
  input  logic        ALU_zero,
  input  logic        Mem_ack,
  output logic        Mem_req,
  output logic        Mem_we,
  output logic        ByteOp,
  output logic        IR_LdEn,
  output logic        PC_LdEn,
  output logic [1:0]  PC_sel,
  output logic        RF_WrEn,
  output logic        RF_Dst_sel,
  output logic        RF_Data_sel,
  output logic        ALU_Bin_sel,
  output logic        ImmExt,
  output logic [3:0]  ALU_func,
  output logic        Illegal_op,
  output logic        Mem_err,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_BEQ, K_BNE, K_J, K_LOAD, K_STORE
  } kind_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             retry_gap;

  kind_t            kind;
  logic             is_r, is_byte, illegal;
  logic [3:0]       dec_func;
  logic             dec_bsel, dec_iext;

  // Only opcode and funct matter here; the jump target bits feed the datapath directly.
  logic unused_instr;
  assign unused_instr = ^Instr[25:6];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    kind     = K_ALU;
    is_r     = 1'b0;
    is_byte  = 1'b0;
    illegal  = 1'b0;
    dec_func = 4'd0;
    dec_bsel = 1'b0;
    dec_iext = 1'b0;
    unique case (Instr[31:26])
      6'b000000: begin
        is_r = 1'b1;
        unique case (Instr[5:0])
          6'b100000: dec_func = 4'd0;
          6'b100010: dec_func = 4'd1;
          6'b100100: dec_func = 4'd2;
          6'b100101: dec_func = 4'd3;
          6'b100110: dec_func = 4'd4;
          6'b100111: dec_func = 4'd5;
          6'b101010: dec_func = 4'd6;
          default:   illegal  = 1'b1;
        endcase
      end
      6'b001000: dec_bsel = 1'b1;
      6'b001100: begin dec_func = 4'd2; dec_bsel = 1'b1; dec_iext = 1'b1; end
      6'b001101: begin dec_func = 4'd3; dec_bsel = 1'b1; dec_iext = 1'b1; end
      6'b001111: begin dec_func = 4'd7; dec_bsel = 1'b1; end
      6'b000100: begin dec_func = 4'd1; kind = K_BEQ; end
      6'b000101: begin dec_func = 4'd1; kind = K_BNE; end
      6'b000010: kind = K_J;
      6'b100011: begin kind = K_LOAD;  dec_bsel = 1'b1; end
      6'b101011: begin kind = K_STORE; dec_bsel = 1'b1; end
      6'b100000: begin kind = K_LOAD;  dec_bsel = 1'b1; is_byte = 1'b1; end
      6'b101000: begin kind = K_STORE; dec_bsel = 1'b1; is_byte = 1'b1; end
      default:   illegal = 1'b1;
    endcase
  end

  // The cycle right after a timeout carries no request, so an ack there cannot count.
  logic ack_ok, waiting, timeout;
  assign ack_ok  = Mem_ack && !retry_gap;
  assign waiting = (state == FETCH) || (state == MEM);
  assign timeout = waiting && !ack_ok && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Resetin) begin
    if (!Resetin) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      retry_gap <= 1'b0;
    end else begin
      retry_gap <= 1'b0;
      unique case (state)
        FETCH: begin
          if (ack_ok) begin
            state    <= DECODE;
            wait_cnt <= '0;
          end else if (timeout) begin
            wait_cnt  <= '0;
            retry_gap <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DECODE: state <= illegal ? FETCH : EXEC;
        EXEC: begin
          unique case (kind)
            K_BEQ, K_BNE, K_J: state <= FETCH;
            K_LOAD, K_STORE:   state <= MEM;
            default:           state <= WB;
          endcase
        end
        MEM: begin
          if (Mem_ack) begin
            state    <= (kind == K_LOAD) ? WB : FETCH;
            wait_cnt <= '0;
          end else if (timeout) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            retry_gap <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WB:      state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  assign State = state;

  // Outputs are decoded from state and gated by Resetin so they drop without a clock edge.
  always_comb begin
    Mem_req     = 1'b0;
    Mem_we      = 1'b0;
    ByteOp      = 1'b0;
    IR_LdEn     = 1'b0;
    PC_LdEn     = 1'b0;
    PC_sel      = 2'd0;
    RF_WrEn     = 1'b0;
    RF_Dst_sel  = 1'b0;
    RF_Data_sel = 1'b0;
    ALU_Bin_sel = 1'b0;
    ImmExt      = 1'b0;
    ALU_func    = 4'd0;
    Illegal_op  = 1'b0;
    Mem_err     = 1'b0;
    if (Resetin) begin
      Mem_err = timeout;
      if (state != FETCH) begin
        ALU_func    = dec_func;
        ALU_Bin_sel = dec_bsel;
        ImmExt      = dec_iext;
      end
      unique case (state)
        FETCH: begin
          Mem_req = !retry_gap;
          IR_LdEn = ack_ok;
          PC_LdEn = ack_ok;
        end
        DECODE: Illegal_op = illegal;
        EXEC: begin
          unique case (kind)
            K_BEQ:   begin PC_LdEn = ALU_zero;  PC_sel = 2'd1; end
            K_BNE:   begin PC_LdEn = !ALU_zero; PC_sel = 2'd1; end
            K_J:     begin PC_LdEn = 1'b1;      PC_sel = 2'd2; end
            default: ;
          endcase
        end
        MEM: begin
          Mem_req = 1'b1;
          Mem_we  = (kind == K_STORE);
          ByteOp  = is_byte;
        end
        WB: begin
          RF_WrEn     = 1'b1;
          RF_Dst_sel  = is_r;
          RF_Data_sel = (kind == K_LOAD);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle
// with MEM_TIMEOUT = 4 and compares the full output bundle against hand-derived values.
module tb_multicycle_ctrl;

  logic        Clk = 1'b0;
  logic        Resetin;
  logic [31:0] Instr;
  logic        ALU_zero, Mem_ack;
  logic        Mem_req, Mem_we, ByteOp, IR_LdEn, PC_LdEn;
  logic [1:0]  PC_sel;
  logic        RF_WrEn, RF_Dst_sel, RF_Data_sel, ALU_Bin_sel, ImmExt;
  logic [3:0]  ALU_func;
  logic        Illegal_op, Mem_err;
  logic [2:0]  State;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .Clk(Clk), .Resetin(Resetin), .Instr(Instr), .ALU_zero(ALU_zero), .Mem_ack(Mem_ack),
    .Mem_req(Mem_req), .Mem_we(Mem_we), .ByteOp(ByteOp), .IR_LdEn(IR_LdEn),
    .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .RF_WrEn(RF_WrEn), .RF_Dst_sel(RF_Dst_sel),
    .RF_Data_sel(RF_Data_sel), .ALU_Bin_sel(ALU_Bin_sel), .ImmExt(ImmExt),
    .ALU_func(ALU_func), .Illegal_op(Illegal_op), .Mem_err(Mem_err), .State(State)
  );

  always #5 Clk = ~Clk;

  // Field order: State, req, we, byte, ir, pcl, pcsel, rfw, dst, dsel, bsel, iext, func, ill, err
  logic [20:0] obs;
  assign obs = {State, Mem_req, Mem_we, ByteOp, IR_LdEn, PC_LdEn, PC_sel, RF_WrEn,
                RF_Dst_sel, RF_Data_sel, ALU_Bin_sel, ImmExt, ALU_func, Illegal_op, Mem_err};

  task automatic check(input string tag, input logic [20:0] observed, input logic [20:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] st,
                            input logic req, we, bop, ir, pcl, input logic [1:0] pcs,
                            input logic rfw, dst, dsel, bsel, iext, input logic [3:0] fn,
                            input logic ill, err);
    check(tag, obs, {st, req, we, bop, ir, pcl, pcs, rfw, dst, dsel, bsel, iext, fn, ill, err});
  endtask

  // Advance one cycle, drive inputs 1 ns after the edge, sample 1 ns later.
  task automatic step(input logic ack, input logic zero, input logic [31:0] ins);
    @(posedge Clk);
    #1;
    Mem_ack  = ack;
    ALU_zero = zero;
    Instr    = ins;
    #1;
  endtask

  // FETCH(ack) -> DECODE -> EXEC -> WB with Mem_ack held high throughout.
  task automatic run_alu(input string tag, input logic [31:0] ins, input logic [3:0] fn,
                         input logic bsel, iext, dst);
    step(1, 0, ins); expect_out({tag, "_fetch"}, 0, 1,0,0,1,1,2'd0, 0,0,0,0,0,4'd0, 0,0);
    step(1, 0, ins); expect_out({tag, "_dec"},   1, 0,0,0,0,0,2'd0, 0,0,0,bsel,iext,fn, 0,0);
    step(1, 0, ins); expect_out({tag, "_exec"},  2, 0,0,0,0,0,2'd0, 0,0,0,bsel,iext,fn, 0,0);
    step(1, 0, ins); expect_out({tag, "_wb"},    4, 0,0,0,0,0,2'd0, 1,dst,0,bsel,iext,fn, 0,0);
  endtask

  // FETCH(ack) -> DECODE -> EXEC for branches and jumps.
  task automatic run_br(input string tag, input logic [31:0] ins, input logic zero,
                        input logic pcl, input logic [1:0] pcs, input logic [3:0] fn);
    step(1, zero, ins); expect_out({tag, "_fetch"}, 0, 1,0,0,1,1,2'd0, 0,0,0,0,0,4'd0, 0,0);
    step(1, zero, ins); expect_out({tag, "_dec"},   1, 0,0,0,0,0,2'd0, 0,0,0,0,0,fn, 0,0);
    step(1, zero, ins); expect_out({tag, "_exec"},  2, 0,0,0,0,pcl,pcs, 0,0,0,0,0,fn, 0,0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Resetin  = 1'b0;
    Mem_ack  = 1'b1;
    ALU_zero = 1'b0;
    Instr    = 32'h0;
    #2;
    expect_out("reset_t0", 0, 0,0,0,0,0,2'd0, 0,0,0,0,0,4'd0, 0,0);
    @(posedge Clk); @(posedge Clk); #1;
    expect_out("reset_held", 0, 0,0,0,0,0,2'd0, 0,0,0,0,0,4'd0, 0,0);
    Mem_ack = 1'b0;
    Resetin = 1'b1;
    #1;
    expect_out("release_req", 0, 1,0,0,0,0,2'd0, 0,0,0,0,0,4'd0, 0,0);

    // ALU ops: 4 cycles each.
    run_alu("add",  32'h00221820, 4'd0, 0, 0, 1);
    run_alu("sub",  32'h00221822, 4'd1, 0, 0, 1);
    run_alu("slt",  32'h0022182A, 4'd6, 0, 0, 1);
    run_alu("ori",  32'h34850008, 4'd3, 1, 1, 0);
    run_alu("andi", 32'h30850008, 4'd2, 1, 1, 0);
    run_alu("lui",  32'h3C050008, 4'd7, 1, 0, 0);

    // lw with 3 wait cycles in MEM; ack lands on the last count value and still succeeds.
    step(1, 0, 32'h8C850008); expect_out("lw_fetch", 0, 1,0,0,1,1,2'd0, 0,0,0,0,0,4'd0, 0,0);
    step(1, 0, 32'h8C850008); expect_out("lw_dec",   1, 0,0,0,0,0,2'd0, 0,0,0,1,0,4'd0, 0,0);
    step(0, 0, 32'h8C850008); expect_out("lw_exec",  2, 0,0,0,0,0,2'd0, 0,0,0,1,0,4'd0, 0,0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'h8C850008);
      expect_out($sformatf("lw_mem_wait%0d", i), 3, 1,0,0,0,0,2'd0, 0,0,0,1,0,4'd0, 0,0);
    end
    step(1, 0, 32'h8C850008); expect_out("lw_mem_ack", 3, 1,0,0,0,0,2'd0, 0,0,0,1,0,4'd0, 0,0);
    step(1, 0, 32'h8C850008); expect_out("lw_wb",      4, 0,0,0,0,0,2'd0, 1,0,1,1,0,4'd0, 0,0);

    // Branches and jump: 3 cycles each.
    run_br("beq_z1", 32'h10220003, 1, 1, 2'd1, 4'd1);
    run_br("beq_z0", 32'h10220003, 0, 0, 2'd1, 4'd1);
    run_br("bne_z1", 32'h14220003, 1, 0, 2'd1, 4'd1);
    run_br("bne_z0", 32'h14220003, 0, 1, 2'd1, 4'd1);
    run_br("j",      32'h08000010, 0, 1, 2'd2, 4'd0);

    // Illegal opcode, then illegal R-type funct.
    step(1, 0, 32'hFC000000); expect_out("ill_op_fetch", 0, 1,0,0,1,1,2'd0, 0,0,0,0,0,4'd0, 0,0);
    step(1, 0, 32'hFC000000); expect_out("ill_op_dec",   1, 0,0,0,0,0,2'd0, 0,0,0,0,0,4'd0, 1,0);
    step(1, 0, 32'h00000001); expect_out("ill_fn_fetch", 0, 1,0,0,1,1,2'd0, 0,0,0,0,0,4'd0, 0,0);
    step(1, 0, 32'h00000001); expect_out("ill_fn_dec",   1, 0,0,0,0,0,2'd0, 0,0,0,0,0,4'd0, 1,0);

    // FETCH timeout: Mem_err every 4th cycle, Mem_req low the cycle after each pulse.
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 32'h00000001);
      expect_out($sformatf("fetch_to_c%0d", i), 0,
                 (i != 5 && i != 9), 0,0,0,0,2'd0, 0,0,0,0,0,4'd0, 0, (i == 4 || i == 8));
    end

    // sb with no ack: MEM times out after 4 cycles, back to FETCH with no write retry.
    step(1, 0, 32'hA0850008); expect_out("sb_fetch", 0, 1,0,0,1,1,2'd0, 0,0,0,0,0,4'd0, 0,0);
    step(1, 0, 32'hA0850008); expect_out("sb_dec",   1, 0,0,0,0,0,2'd0, 0,0,0,1,0,4'd0, 0,0);
    step(0, 0, 32'hA0850008); expect_out("sb_exec",  2, 0,0,0,0,0,2'd0, 0,0,0,1,0,4'd0, 0,0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 32'hA0850008);
      expect_out($sformatf("sb_mem_c%0d", i), 3, 1,1,1,0,0,2'd0, 0,0,0,1,0,4'd0, 0, (i == 4));
    end
    step(0, 0, 32'hA0850008); expect_out("sb_abort_gap", 0, 0,0,0,0,0,2'd0, 0,0,0,0,0,4'd0, 0,0);

    // addi, then asynchronous reset in the middle of WB.
    run_alu("addi", 32'h20850008, 4'd0, 1, 0, 0);
    Resetin = 1'b0;
    #1;
    expect_out("reset_in_wb", 0, 0,0,0,0,0,2'd0, 0,0,0,0,0,4'd0, 0,0);
    step(1, 0, 32'h20850008); expect_out("reset_in_wb_held", 0, 0,0,0,0,0,2'd0, 0,0,0,0,0,4'd0, 0,0);
    Resetin = 1'b1;
    #1;
    expect_out("rerelease_fetch", 0, 1,0,0,1,1,2'd0, 0,0,0,0,0,4'd0, 0,0);
    step(1, 0, 32'h20850008); expect_out("rerelease_dec", 1, 0,0,0,0,0,2'd0, 0,0,0,1,0,4'd0, 0,0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS processor datapath: PC, IR, register file, ALU and unified instruction/data memory.
- Decodes the IR contents and sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives every datapath enable and mux select, and handles a req/ack memory handshake with a timeout.
- Sits beside the datapath inside PROCESSOR and replaces the single-cycle control unit.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait for Mem_ack per access before abort; legal range 2..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- Clk  in  1  system clock, rising edge.
- Resetin  in  1  asynchronous, active-low reset (0 = reset).
- Instr  in  32  IR output; stable from DECODE to the end of the instruction.
- ALU_zero  in  1  ALU zero flag, valid in EXEC.
- Mem_ack  in  1  memory completion, sampled at the rising edge.
- Mem_req  out  1  memory access request.
- Mem_we  out  1  memory write, qualified by Mem_req.
- ByteOp  out  1  byte access (lb/sb).
- IR_LdEn  out  1  load IR from memory output.
- PC_LdEn  out  1  load PC.
- PC_sel  out  2  PC source: 0 = PC+4, 1 = PC+4+(sext(imm)<<2), 2 = {PC[31:28], Instr[25:0], 2'b00}.
- RF_WrEn  out  1  register file write.
- RF_Dst_sel  out  1  write register: 0 = rt, 1 = rd.
- RF_Data_sel  out  1  write data: 0 = ALU result, 1 = memory data.
- ALU_Bin_sel  out  1  ALU B operand: 0 = RF_B, 1 = immediate.
- ImmExt  out  1  immediate extension: 0 = sign, 1 = zero.
- ALU_func  out  4  ALU operation code.
- Illegal_op  out  1  one-cycle pulse on an undefined opcode or funct.
- Mem_err  out  1  one-cycle pulse on memory timeout.
- State  out  3  current state, for debug.

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4.
- Reset: while Resetin = 0, the FSM is in FETCH, the wait counter is 0 and all outputs are 0. Mem_req is combinational from state, so it also reads 0 during reset.
- First cycle after reset release: FETCH with Mem_req = 1.
- FETCH:
  - Mem_req = 1, Mem_we = 0, ByteOp = 0.
  - Stays in FETCH until Mem_ack = 1.
  - In the cycle where Mem_ack = 1: IR_LdEn = 1, PC_LdEn = 1, PC_sel = 0, then go to DECODE.
- DECODE: no enables asserted; opcode/funct are checked.
  - Undefined opcode or funct: Illegal_op = 1 for one cycle, then go to FETCH. No writes occur; PC has already advanced by 4.
- Supported opcodes (Instr[31:26]): R = 000000, addi = 001000, andi = 001100, ori = 001101, lui = 001111, beq = 000100, bne = 000101, j = 000010, lw = 100011, sw = 101011, lb = 100000, sb = 101000.
- R-type funct to ALU_func: add 100000 → 0, sub 100010 → 1, and 100100 → 2, or 100101 → 3, xor 100110 → 4, nor 100111 → 5, slt 101010 → 6. Any other funct is illegal.
- I-type ALU_func: addi / lw / sw / lb / sb → 0 (ADD); andi → 2; ori → 3; lui → 7 (B << 16); beq / bne → 1 (SUB).
- ImmExt = 1 for andi and ori only. ALU_Bin_sel = 1 for all I-type except beq and bne.
- ALU_func, ALU_Bin_sel and ImmExt are held from DECODE until the instruction completes.
- EXEC:
  - beq: PC_LdEn = ALU_zero, PC_sel = 1, then FETCH.
  - bne: PC_LdEn = !ALU_zero, PC_sel = 1, then FETCH.
  - j: PC_LdEn = 1, PC_sel = 2, then FETCH.
  - Loads and stores: go to MEM.
  - All other instructions: go to WB.
- MEM:
  - Mem_req = 1; Mem_we = 1 for sw/sb; ByteOp = 1 for lb/sb.
  - Waits for Mem_ack.
  - On ack: loads go to WB; stores go to FETCH.
- WB (one cycle):
  - RF_WrEn = 1.
  - RF_Dst_sel = 1 for R-type, else 0.
  - RF_Data_sel = 1 for lw/lb, else 0.
  - Then FETCH.
- Wait counter and timeout:
  - The counter increments in each FETCH or MEM cycle without Mem_ack and clears on ack or on state change.
  - When the counter = MEM_TIMEOUT−1 and Mem_ack = 0: Mem_err = 1 for that cycle, the counter clears, and the FSM goes to FETCH (Mem_req drops for one cycle).
  - Timeout in FETCH: the fetch is retried at the same PC.
  - Timeout in MEM: the instruction is aborted with no RF write.
  - Mem_ack on the same cycle as the timeout count is treated as success.
- Instruction latency with zero-wait memory (Mem_ack already high):
  - ALU ops: 4 cycles.
  - Loads: 5 cycles.
  - Stores: 4 cycles.
  - Branches and j: 3 cycles.
  - Each memory wait cycle adds 1.
- Mem_ack outside FETCH/MEM is ignored.
- Resetin asserted mid-instruction: immediate asynchronous return to FETCH with all outputs 0. Any pending write is abandoned.

Test Plan:
- Mem_ack tied 1, Instr = add $3,$1,$2 (0x00221820) → States 0,1,2,4. ALU_func = 0, RF_Dst_sel = 1, RF_WrEn = 1 only in WB. PC_LdEn once in FETCH with PC_sel = 0.
- lw $5,8($4) (0x8C850008) with Mem_ack delayed 3 cycles in MEM → MEM lasts 4 cycles with Mem_req = 1 and Mem_we = 0. WB has RF_Data_sel = 1 and RF_Dst_sel = 0. Total 8 cycles.
- beq (0x10220003) with ALU_zero = 1 → PC_LdEn = 1, PC_sel = 1 in EXEC. Repeat with ALU_zero = 0 → PC_LdEn = 0. bne gives the opposite result in both cases. j 0x08000010 → PC_sel = 2.
- Instr opcode 111111, then R-type funct 000001 → Illegal_op pulses exactly 1 cycle in DECODE. RF_WrEn and Mem_we are never set. Next state is FETCH.
- MEM_TIMEOUT = 4, Mem_ack held 0 in FETCH → Mem_err pulses every 4th cycle, Mem_req drops one cycle after each pulse, IR_LdEn stays 0. sb with no ack → Mem_err pulses, then FETCH with no write retry.
- Resetin driven 0 during WB of an addi → outputs 0 and State = 0 immediately, without waiting for a clock edge. On release, Mem_req = 1 in the first cycle.
